matrix_scan_db: RTL and testbench

MATRIX_SCAN_DB -- requirements
Module: matrix_scan_db

---
 rtl/matrix_scan_db.sv | 153 +++++++++++++++
 tb/tb_matrix_scan_db.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_db.sv
// matrix_scan_db -- multiplexed bi-colour LED matrix scanner with double buffer.
//
// Scans ROWS rows, dwelling DIV clk cycles on each. The first BLANK cycles of
// every dwell are blanked (rows off, columns off) to hide ghosting while the
// row drivers switch. Writes go to a back buffer. A swap request is held
// pending and taken at the next frame boundary, so a frame is never torn.
//
// Optional feature: define MATRIX_BLINK_EN to build a blink phase that toggles
// every BLINK_FRAMES frames and blanks the columns while blink_en=1 and the
// phase is off. Without it blink_en is ignored and no blink counter exists.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_en        write strobe into the back buffer
//   wr_row       target row of the write (out-of-range rows are ignored)
//   wr_r, wr_g   red / green column data for the write
//   swap_req     request a front/back exchange at the next frame boundary
//   blink_en     blink enable (used only with MATRIX_BLINK_EN)
//   swap_ack     one-cycle pulse on the cycle the swap takes effect
//   frame_start  one-cycle pulse when the row index wraps to 0
//   col_r, col_g active-high column drive, registered
//   row          active-low one-hot row select, registered (index 0 -> MSB)

module matrix_scan_db #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DIV          = 62500,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_r,
    input  logic [COLS-1:0]         wr_g,
    input  logic                    swap_req,
    input  logic                    blink_en,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [COLS-1:0]         col_r,
    output logic [COLS-1:0]         col_g,
    output logic [ROWS-1:0]         row
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0]   BLANK_L = CW'(BLANK);
    localparam logic [RW-1:0]   IDX_MAX = RW'(ROWS - 1);
    localparam logic [RW:0]     ROWS_L  = (RW + 1)'(ROWS);
    localparam logic [ROWS-1:0] ROW_MSB = {1'b1, {(ROWS - 1){1'b0}}};

    logic [CW-1:0]   cnt;
    logic [RW-1:0]   idx;
    logic            bank;      // selects which buffer is front
    logic            pending;

    logic [COLS-1:0] buf_r [2][ROWS];
    logic [COLS-1:0] buf_g [2][ROWS];

    logic dwell_end;
    logic frame_end;
    logic do_swap;
    logic in_blank;
    logic wr_ok;
    logic blink_off;

    assign dwell_end = (cnt == CNT_MAX);
    assign frame_end = dwell_end && (idx == IDX_MAX);
    assign do_swap   = frame_end && (pending || swap_req);
    assign in_blank  = (cnt < BLANK_L);
    assign wr_ok     = wr_en && ({1'b0, wr_row} < ROWS_L);

`ifdef MATRIX_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BF_MAX = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    // Advances on the same event that raises frame_start, so the phase
    // changes exactly at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BF_MAX) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign blink_off = blink_en && !blink_on;
`else
    logic unused_blink;
    assign unused_blink = blink_en;
    assign blink_off    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            bank        <= 1'b0;
            pending     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            row         <= '1;
            col_r       <= '0;
            col_g       <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    buf_r[b][i] <= '0;
                    buf_g[b][i] <= '0;
                end
            end
        end else begin
            cnt <= dwell_end ? '0 : cnt + CW'(1);
            if (dwell_end) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + RW'(1);
            end

            // The back buffer is written even in the swap cycle, so that
            // write ends up in the buffer that is about to become front.
            if (wr_ok) begin
                buf_r[~bank][wr_row] <= wr_r;
                buf_g[~bank][wr_row] <= wr_g;
            end

            if (do_swap) begin
                bank    <= ~bank;
                pending <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end

            swap_ack    <= do_swap;
            frame_start <= frame_end;

            row   <= in_blank ? '1 : ~(ROW_MSB >> idx);
            col_r <= (in_blank || blink_off) ? '0 : buf_r[bank][idx];
            col_g <= (in_blank || blink_off) ? '0 : buf_g[bank][idx];
        end
    end

endmodule

// File: tb/tb_matrix_scan_db.sv
// Testbench for matrix_scan_db (ROWS=8, COLS=8, DIV=10, BLANK=2, BLINK_FRAMES=2).
// The stimulus process drives one cycle at a time and pushes the output tuple
// it expects after that edge; the monitor pops and compares on the falling edge.

module tb_matrix_scan_db;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = ROWS * DIV;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_r;
    logic [COLS-1:0] wr_g;
    logic            swap_req;
    logic            blink_en;
    logic            swap_ack;
    logic            frame_start;
    logic [COLS-1:0] col_r;
    logic [COLS-1:0] col_g;
    logic [ROWS-1:0] row;

    matrix_scan_db #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row),
        .wr_r(wr_r), .wr_g(wr_g), .swap_req(swap_req), .blink_en(blink_en),
        .swap_ack(swap_ack), .frame_start(frame_start),
        .col_r(col_r), .col_g(col_g), .row(row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    typedef struct {
        int         tag;
        logic [7:0] row;
        logic [7:0] r;
        logic [7:0] g;
        logic       ack;
        logic       fs;
    } exp_t;

    exp_t q[$];

    // reference state, owned by the stimulus process
    logic [7:0] fr_r [8];
    logic [7:0] fr_g [8];
    logic [7:0] bk_r [8];
    logic [7:0] bk_g [8];
    bit         pend;
    int         s;
    bit         blink_drv;
    bit         done;

    task automatic cycle(input bit rst, input bit we, input logic [2:0] wrow,
                         input logic [7:0] r, input logic [7:0] g, input bit sw);
        exp_t e;
        int p, c, i;
        bit bnd, dosw, gate;
        logic [7:0] t;
        rst_n    = !rst;
        wr_en    = we;
        wr_row   = wrow;
        wr_r     = r;
        wr_g     = g;
        swap_req = sw;
        blink_en = blink_drv;
        e.tag = tcyc + 1;
        if (rst) begin
            e.row = 8'hFF; e.r = 8'h00; e.g = 8'h00; e.ack = 1'b0; e.fs = 1'b0;
            s = 0;
            pend = 0;
            for (int k = 0; k < 8; k++) begin
                fr_r[k] = 8'h00; fr_g[k] = 8'h00; bk_r[k] = 8'h00; bk_g[k] = 8'h00;
            end
        end else begin
            p   = s;
            c   = p % DIV;
            i   = (p / DIV) % ROWS;
            bnd = (p % FRAME) == FRAME - 1;
`ifdef MATRIX_BLINK_EN
            gate = blink_drv && ((((p / FRAME) / BF) % 2) == 1);
`else
            gate = 1'b0;
`endif
            e.row = (c < BLANK) ? 8'hFF : ~(8'h80 >> i);
            e.r   = (c < BLANK || gate) ? 8'h00 : fr_r[i];
            e.g   = (c < BLANK || gate) ? 8'h00 : fr_g[i];
            e.fs  = bnd;
            dosw  = bnd && (pend || sw);
            e.ack = dosw;
            if (we) begin
                bk_r[wrow] = r;
                bk_g[wrow] = g;
            end
            if (dosw) begin
                for (int k = 0; k < 8; k++) begin
                    t = fr_r[k]; fr_r[k] = bk_r[k]; bk_r[k] = t;
                    t = fr_g[k]; fr_g[k] = bk_g[k]; bk_g[k] = t;
                end
                pend = 0;
            end else if (sw) begin
                pend = 1;
            end
            s++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_r = 8'h00; wr_g = 8'h00;
        swap_req = 1'b0; blink_en = 1'b0; blink_drv = 1'b0; done = 1'b0;
        s = 0; pend = 0;
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        repeat (35) idle();
        // reset in the middle of row 3's dwell
        repeat (3) cycle(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        // write + swap; second request collapses into the first
        cycle(1'b0, 1'b1, 3'd0, 8'h81, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 3'd3, 8'h18, 8'h3C, 1'b0);
        cycle(1'b0, 1'b1, 3'd5, 8'h00, 8'hA5, 1'b0);
        repeat (5) idle();
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        repeat (10) idle();
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        repeat (80) idle();
        // writes without any swap request: display must not change
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, i[2:0], 8'(i * 17 + 1), 8'(8'hF0 ^ i), 1'b0);
        end
        repeat (240) idle();
        // swap and write coincide on the boundary cycle
        while ((s % FRAME) != FRAME - 1) idle();
        cycle(1'b0, 1'b1, 3'd7, 8'hFF, 8'h0F, 1'b1);
        repeat (85) idle();
        // swap back with no writes: old front returns untouched
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        repeat (100) idle();
        blink_drv = 1'b1;
        repeat (400) idle();
        blink_drv = 1'b0;
        repeat (5) idle();
        done = 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int acks   = 0;
    int last_fs = -1;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].tag < tcyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_sample tag=%0d now=%0d", e.tag, tcyc);
        end
        if (q.size() != 0 && q[0].tag == tcyc) begin
            e = q.pop_front();
            checks++;
            if ({row, col_r, col_g, swap_ack, frame_start} !== {e.row, e.r, e.g, e.ack, e.fs}) begin
                errors++;
                $display("FAIL outputs cyc=%0d row=%h want %h r=%h want %h g=%h want %h ack=%b want %b fs=%b want %b",
                         tcyc, row, e.row, col_r, e.r, col_g, e.g, swap_ack, e.ack, frame_start, e.fs);
            end
        end
        if (rst_n === 1'b1 && swap_ack === 1'b1) acks++;
        if (rst_n !== 1'b1) begin
            last_fs = -1;
        end else if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                checks++;
                if (tcyc - last_fs != FRAME) begin
                    errors++;
                    $display("FAIL frame_period got %0d want %0d", tcyc - last_fs, FRAME);
                end
            end
            last_fs = tcyc;
        end
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain left %0d want 0", q.size());
            end
            checks++;
            if (acks != 3) begin
                errors++;
                $display("FAIL swap_ack_count got %0d want 3", acks);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
